// File: rtl/emio_counter_bank_pkg.sv
// Shared types and helpers for the EMIO counter bank.
package emio_counter_pkg;

  // Per-channel counting mode, two bits per channel on the mode bus.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } cnt_mode_t;

  // All-ones value for a counter of the given width (up to 64 bits).
  function automatic logic [63:0] cnt_max(input int unsigned width);
    logic [63:0] one;
    one = 64'd1;
    if (width >= 64) begin
      return '1;
    end
    return (one << width) - one;
  endfunction

endpackage

// File: rtl/emio_counter_bank_channel.sv
// One up/down counter channel: load > step > hold, with WRAP, SATURATE,
// ONESHOT and HOLD boundary behaviour and a registered terminal-count pulse.
module counter_channel
  import emio_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             en,
  input  logic             dir,
  input  cnt_mode_t        mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;

  logic             step;
  logic             at_top, at_bot;
  logic             near_top, near_bot;
  logic [WIDTH-1:0] inc, dec;

  assign step     = tick && en && (mode != MODE_HOLD) && !done_q;
  assign at_top   = (count_q == MAX);
  assign at_bot   = (count_q == '0);
  assign near_top = (count_q == MAX - ONE);
  assign near_bot = (count_q == ONE);
  assign inc      = count_q + ONE;
  assign dec      = count_q - ONE;

  // Next count, done flag and terminal-count pulse for this cycle.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
      done_d  = 1'b0;
    end else if (step) begin
      case (mode)
        MODE_WRAP: begin
          count_d = dir ? inc : dec;
          tc_d    = dir ? at_top : at_bot;
        end
        MODE_SAT, MODE_ONESHOT: begin
          // Already sitting on the boundary in the step direction: hold, no pulse.
          if (dir ? !at_top : !at_bot) begin
            count_d = dir ? inc : dec;
            tc_d    = dir ? near_top : near_bot;
            done_d  = (mode == MODE_ONESHOT) && (dir ? near_top : near_bot);
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: rtl/emio_counter_bank.sv
// Bank of independent up/down counters behind a shared prescaler, with a
// selectable channel/bit slice registered onto the board LEDs.
module emio_counter_bank
  import emio_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned PRESCALE_W = 8,
  parameter int unsigned LED_LSB    = 24,
  parameter int unsigned LED_W      = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [CHANNELS-1:0]                             en,
  input  logic [CHANNELS-1:0]                             dir,
  input  logic [2*CHANNELS-1:0]                           mode,
  input  logic [CHANNELS-1:0]                             load,
  input  logic [WIDTH-1:0]                                load_val,
  input  logic [PRESCALE_W-1:0]                           prescale,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] led_sel,
  output logic [CHANNELS*WIDTH-1:0]                       count,
  output logic [CHANNELS-1:0]                             tc,
  output logic [LED_W-1:0]                                led
);

  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  tick;
  logic [WIDTH-1:0]      count_arr [CHANNELS];
  logic [LED_W-1:0]      led_q, led_d;

  // Using >= rather than == means lowering prescale below the running
  // count still ticks on the next cycle instead of locking up.
  assign tick      = (pre_cnt_q >= prescale);
  assign pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);

  // Prescaler counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    counter_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .en       (en[g]),
      .dir      (dir[g]),
      .mode     (cnt_mode_t'(mode[2*g +: 2])),
      .load     (load[g]),
      .load_val (load_val),
      .count    (count_arr[g]),
      .tc       (tc[g])
    );
    assign count[g*WIDTH +: WIDTH] = count_arr[g];
  end

  // LED slice mux; unmatched (out-of-range) selects fall back to channel 0.
  always_comb begin
    led_d = count_arr[0][LED_LSB +: LED_W];
    for (int unsigned i = 1; i < CHANNELS; i++) begin
      if (led_sel == SEL_W'(i)) begin
        led_d = count_arr[i][LED_LSB +: LED_W];
      end
    end
  end

  // LED output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule
